// File: rtl/mips_data_path.sv
// ---------------------------------------------------------------------------
// mips_data_path
//   Single-cycle 32-bit MIPS core (integer subset). The PC, instruction ROM,
//   32x32 register file, ALU, data RAM and main/ALU decode are all in this
//   block. Each rising clock edge commits exactly one instruction.
//
// Ports
//   clk        in   1   system clock; all state updates on the rising edge
//   initiate   in   1   asynchronous active-low reset (0 = in reset)
//   pc_o       out  32  current PC
//   wb_en_o    out  1   register-file write strobe for this cycle
//   wb_addr_o  out  5   destination register index for this cycle
//   wb_data_o  out  32  write-back value for this cycle
// ---------------------------------------------------------------------------
module mips_data_path #(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        initiate,
  output logic [31:0] pc_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Instruction ROM. It is never touched by reset; the memory image is
  // placed by whoever owns the memory.
  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] immSext;
  logic [31:0] rsVal, rtVal;
  logic [31:0] pcPlus4, brTarget, jTarget;
  logic [31:0] aluRes, memRead, wbData;
  logic [4:0]  destReg;
  logic        regWrite, isLw, isSw, wbEn;

  assign instr   = imem[pc_q[IAW+1:2]];
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign immSext = {{16{instr[15]}}, instr[15:0]};

  // $0 is forced to zero on read so that it can never leak a stale value.
  assign rsVal = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rtVal = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  assign pcPlus4  = pc_q + 32'd4;
  assign brTarget = pcPlus4 + {immSext[29:0], 2'b00};
  assign jTarget  = {pcPlus4[31:28], instr[25:0], 2'b00};

  // Main and ALU decode. Anything not recognised falls through as a NOP:
  // no register write, no store, PC advances by 4.
  always_comb begin
    regWrite = 1'b0;
    isLw     = 1'b0;
    isSw     = 1'b0;
    destReg  = rt;
    aluRes   = 32'd0;
    pc_d     = pcPlus4;
    case (opcode)
      OP_RTYPE: begin
        destReg = rd;
        case (funct)
          FN_ADD: begin aluRes = rsVal + rtVal; regWrite = 1'b1; end
          FN_SUB: begin aluRes = rsVal - rtVal; regWrite = 1'b1; end
          FN_AND: begin aluRes = rsVal & rtVal; regWrite = 1'b1; end
          FN_OR:  begin aluRes = rsVal | rtVal; regWrite = 1'b1; end
          FN_SLT: begin
            aluRes   = ($signed(rsVal) < $signed(rtVal)) ? 32'd1 : 32'd0;
            regWrite = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin aluRes = rsVal + immSext; regWrite = 1'b1; end
      OP_LW: begin
        aluRes   = rsVal + immSext;
        isLw     = 1'b1;
        regWrite = 1'b1;
      end
      OP_SW: begin
        aluRes = rsVal + immSext;
        isSw   = 1'b1;
      end
      OP_BEQ: begin
        if (rsVal == rtVal) pc_d = brTarget;
      end
      OP_J: pc_d = jTarget;
      default: ;
    endcase
  end

  // Word addressing: the byte offset bits are dropped and the index wraps
  // naturally because only log2(depth) bits are kept.
  assign memRead = dmem_q[aluRes[DAW+1:2]];
  assign wbData  = isLw ? memRead : aluRes;
  assign wbEn    = regWrite && (destReg != 5'd0);

  assign pc_o      = pc_q;
  assign wb_en_o   = wbEn;
  assign wb_addr_o = destReg;
  assign wb_data_o = wbData;

  // Program counter.
  always_ff @(posedge clk or negedge initiate) begin
    if (!initiate) pc_q <= 32'd0;
    else           pc_q <= pc_d;
  end

  // Register file; a write lands on the edge and is seen from the next cycle.
  always_ff @(posedge clk or negedge initiate) begin
    if (!initiate) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wbEn) begin
      regs_q[destReg] <= wbData;
    end
  end

  // Data RAM: combinational read above, synchronous write here, cleared by reset.
  always_ff @(posedge clk or negedge initiate) begin
    if (!initiate) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'd0;
    end else if (isSw) begin
      dmem_q[aluRes[DAW+1:2]] <= rtVal;
    end
  end

endmodule

// File: tb/tb_mips_data_path.sv
// ---------------------------------------------------------------------------
// tb_mips_data_path
//   Directed bench for the single-cycle MIPS core. Programs are written
//   straight into the instruction ROM while the core is held in reset, and
//   every committed instruction is compared against hand-computed PC and
//   write-back values.
// ---------------------------------------------------------------------------
module tb_mips_data_path;

  logic        clk;
  logic        initiate;
  logic [31:0] pc_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog    [$];
  logic [31:0] expPc   [$];
  logic        expEn   [$];
  logic [4:0]  expAddr [$];
  logic [31:0] expData [$];

  mips_data_path #(
    .IMEM_DEPTH(256),
    .DMEM_DEPTH(256),
    .IMEM_FILE ("")
  ) dut (
    .clk      (clk),
    .initiate (initiate),
    .pc_o     (pc_o),
    .wb_en_o  (wb_en_o),
    .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jType(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  // Queue one expected commit: PC, strobe, and (when strobed) address/data.
  task automatic expect1(input logic [31:0] pc, input logic en,
                         input logic [4:0] a, input logic [31:0] d);
    expPc.push_back(pc);
    expEn.push_back(en);
    expAddr.push_back(a);
    expData.push_back(d);
  endtask

  task automatic clearQueues();
    prog.delete();
    expPc.delete();
    expEn.delete();
    expAddr.delete();
    expData.delete();
  endtask

  // Hold reset, wipe the ROM to NOPs, place the program, then release on a
  // falling edge so the next rising edge commits the word at address 0.
  task automatic loadAndStart();
    initiate = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
    #20;
    @(negedge clk);
    initiate = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int nonZero;
    initiate = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    dut.imem[0] = iType(6'h2B, 5'd0, 5'd1, 16'h0000);
    #100;
    @(negedge clk);
    checks++;
    if (pc_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h expected %h", pc_o, 32'd0);
    end
    checks++;
    if (wb_en_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wb_en: got %b expected 0", wb_en_o);
    end
    nonZero = 0;
    for (int i = 0; i < 32; i++) if (dut.regs_q[i] !== 32'd0) nonZero++;
    checks++;
    if (nonZero != 0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %0d nonzero registers expected 0", nonZero);
    end
    nonZero = 0;
    for (int i = 0; i < 256; i++) if (dut.dmem_q[i] !== 32'd0) nonZero++;
    checks++;
    if (nonZero != 0) begin
      errors++;
      $display("[TB] FAIL reset_dmem: got %0d nonzero words expected 0", nonZero);
    end
  endtask

  task automatic test_arith();
    clearQueues();
    prog.push_back(iType(6'h08, 5'd0, 5'd1, 16'd5));    expect1(32'h00, 1'b1, 5'd1, 32'd5);
    prog.push_back(iType(6'h08, 5'd0, 5'd2, 16'hFFFD)); expect1(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFD);
    prog.push_back(rType(5'd1, 5'd2, 5'd3, 6'h20));     expect1(32'h08, 1'b1, 5'd3, 32'd2);
    prog.push_back(rType(5'd1, 5'd2, 5'd4, 6'h22));     expect1(32'h0C, 1'b1, 5'd4, 32'd8);
    prog.push_back(rType(5'd2, 5'd1, 5'd5, 6'h2A));     expect1(32'h10, 1'b1, 5'd5, 32'd1);
    prog.push_back(rType(5'd1, 5'd2, 5'd6, 6'h2A));     expect1(32'h14, 1'b1, 5'd6, 32'd0);
    prog.push_back(rType(5'd3, 5'd4, 5'd7, 6'h3F));     expect1(32'h18, 1'b0, 5'd0, 32'd0);
    prog.push_back(rType(5'd3, 5'd4, 5'd8, 6'h20));     expect1(32'h1C, 1'b1, 5'd8, 32'd10);
    loadAndStart();
    for (int k = 0; k < expPc.size(); k++) begin
      checks++;
      if (pc_o !== expPc[k] || wb_en_o !== expEn[k] ||
          (expEn[k] && (wb_addr_o !== expAddr[k] || wb_data_o !== expData[k]))) begin
        errors++;
        $display("[TB] FAIL arith[%0d]: got pc=%h en=%b addr=%0d data=%h expected pc=%h en=%b addr=%0d data=%h",
                 k, pc_o, wb_en_o, wb_addr_o, wb_data_o, expPc[k], expEn[k], expAddr[k], expData[k]);
      end
      tick();
    end
  endtask

  task automatic test_logic();
    clearQueues();
    prog.push_back(iType(6'h08, 5'd0, 5'd1, 16'h00F0)); expect1(32'h00, 1'b1, 5'd1, 32'h0000_00F0);
    prog.push_back(iType(6'h08, 5'd0, 5'd2, 16'h003C)); expect1(32'h04, 1'b1, 5'd2, 32'h0000_003C);
    prog.push_back(rType(5'd1, 5'd2, 5'd3, 6'h24));     expect1(32'h08, 1'b1, 5'd3, 32'h0000_0030);
    prog.push_back(rType(5'd1, 5'd2, 5'd4, 6'h25));     expect1(32'h0C, 1'b1, 5'd4, 32'h0000_00FC);
    loadAndStart();
    for (int k = 0; k < expPc.size(); k++) begin
      checks++;
      if (pc_o !== expPc[k] || wb_en_o !== expEn[k] ||
          (expEn[k] && (wb_addr_o !== expAddr[k] || wb_data_o !== expData[k]))) begin
        errors++;
        $display("[TB] FAIL logic[%0d]: got pc=%h en=%b addr=%0d data=%h expected pc=%h en=%b addr=%0d data=%h",
                 k, pc_o, wb_en_o, wb_addr_o, wb_data_o, expPc[k], expEn[k], expAddr[k], expData[k]);
      end
      tick();
    end
  endtask

  task automatic test_memory();
    clearQueues();
    prog.push_back(iType(6'h08, 5'd0, 5'd6, 16'h55AA)); expect1(32'h00, 1'b1, 5'd6, 32'h0000_55AA);
    prog.push_back(iType(6'h2B, 5'd0, 5'd6, 16'h0008)); expect1(32'h04, 1'b0, 5'd0, 32'd0);
    prog.push_back(iType(6'h23, 5'd0, 5'd7, 16'h0008)); expect1(32'h08, 1'b1, 5'd7, 32'h0000_55AA);
    prog.push_back(rType(5'd7, 5'd0, 5'd9, 6'h20));     expect1(32'h0C, 1'b1, 5'd9, 32'h0000_55AA);
    // 0x40C wraps to word 3; reading it back at 0xC proves the wrap.
    prog.push_back(iType(6'h2B, 5'd0, 5'd9, 16'h040C)); expect1(32'h10, 1'b0, 5'd0, 32'd0);
    prog.push_back(iType(6'h23, 5'd0, 5'd8, 16'h000C)); expect1(32'h14, 1'b1, 5'd8, 32'h0000_55AA);
    // Byte offset 0xB still selects word 2.
    prog.push_back(iType(6'h23, 5'd0, 5'd10, 16'h000B)); expect1(32'h18, 1'b1, 5'd10, 32'h0000_55AA);
    // Word 5 was never written and must read as zero.
    prog.push_back(iType(6'h23, 5'd0, 5'd11, 16'h0014)); expect1(32'h1C, 1'b1, 5'd11, 32'd0);
    loadAndStart();
    for (int k = 0; k < expPc.size(); k++) begin
      checks++;
      if (pc_o !== expPc[k] || wb_en_o !== expEn[k] ||
          (expEn[k] && (wb_addr_o !== expAddr[k] || wb_data_o !== expData[k]))) begin
        errors++;
        $display("[TB] FAIL memory[%0d]: got pc=%h en=%b addr=%0d data=%h expected pc=%h en=%b addr=%0d data=%h",
                 k, pc_o, wb_en_o, wb_addr_o, wb_data_o, expPc[k], expEn[k], expAddr[k], expData[k]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    for (int run = 0; run < 2; run++) begin
      clearQueues();
      for (int i = 0; i < 65; i++) prog.push_back(32'h0);
      prog[0] = iType(6'h08, 5'd0, 5'd1, 16'd1); expect1(32'h00, 1'b1, 5'd1, 32'd1);
      prog[1] = iType(6'h08, 5'd0, 5'd2, 16'd2); expect1(32'h04, 1'b1, 5'd2, 32'd2);
      expect1(32'h08, 1'b0, 5'd0, 32'd0);
      expect1(32'h0C, 1'b0, 5'd0, 32'd0);
      if (run == 0) begin
        prog[4] = iType(6'h04, 5'd1, 5'd1, 16'd2); expect1(32'h10, 1'b0, 5'd0, 32'd0);
        prog[7] = iType(6'h08, 5'd0, 5'd3, 16'd3); expect1(32'h1C, 1'b1, 5'd3, 32'd3);
        // Backward branch from 0x20 to 0x08 (offset -7).
        prog[8] = iType(6'h04, 5'd2, 5'd2, 16'hFFF9); expect1(32'h20, 1'b0, 5'd0, 32'd0);
        expect1(32'h08, 1'b0, 5'd0, 32'd0);
      end else begin
        prog[4]  = iType(6'h04, 5'd1, 5'd2, 16'd2); expect1(32'h10, 1'b0, 5'd0, 32'd0);
        prog[5]  = jType(26'h40);                   expect1(32'h14, 1'b0, 5'd0, 32'd0);
        prog[64] = iType(6'h08, 5'd0, 5'd4, 16'd4); expect1(32'h100, 1'b1, 5'd4, 32'd4);
        expect1(32'h104, 1'b0, 5'd0, 32'd0);
      end
      loadAndStart();
      for (int k = 0; k < expPc.size(); k++) begin
        checks++;
        if (pc_o !== expPc[k] || wb_en_o !== expEn[k] ||
            (expEn[k] && (wb_addr_o !== expAddr[k] || wb_data_o !== expData[k]))) begin
          errors++;
          $display("[TB] FAIL branch%0d[%0d]: got pc=%h en=%b addr=%0d data=%h expected pc=%h en=%b addr=%0d data=%h",
                   run, k, pc_o, wb_en_o, wb_addr_o, wb_data_o, expPc[k], expEn[k], expAddr[k], expData[k]);
        end
        tick();
      end
    end
  endtask

  task automatic test_edge();
    logic [31:0] pc;
    clearQueues();
    prog.push_back(iType(6'h08, 5'd0, 5'd0, 16'd7)); expect1(32'h00, 1'b0, 5'd0, 32'd0);
    prog.push_back(rType(5'd0, 5'd0, 5'd11, 6'h25)); expect1(32'h04, 1'b1, 5'd11, 32'd0);
    prog.push_back(iType(6'h08, 5'd0, 5'd1, 16'd1)); expect1(32'h08, 1'b1, 5'd1, 32'd1);
    pc = 32'h0C;
    // Doubling 31 times walks the single set bit up to bit 31.
    for (int i = 1; i <= 31; i++) begin
      prog.push_back(rType(5'd1, 5'd1, 5'd1, 6'h20));
      expect1(pc, 1'b1, 5'd1, 32'd1 << i);
      pc += 4;
    end
    prog.push_back(iType(6'h08, 5'd1, 5'd2, 16'hFFFF)); expect1(pc, 1'b1, 5'd2, 32'h7FFF_FFFF); pc += 4;
    prog.push_back(iType(6'h08, 5'd2, 5'd3, 16'd1));    expect1(pc, 1'b1, 5'd3, 32'h8000_0000); pc += 4;
    prog.push_back(iType(6'h08, 5'd0, 5'd5, 16'd1));    expect1(pc, 1'b1, 5'd5, 32'd1);         pc += 4;
    prog.push_back(rType(5'd2, 5'd5, 5'd6, 6'h20));     expect1(pc, 1'b1, 5'd6, 32'h8000_0000); pc += 4;
    prog.push_back(rType(5'd3, 5'd5, 5'd7, 6'h2A));     expect1(pc, 1'b1, 5'd7, 32'd1);         pc += 4;
    prog.push_back(rType(5'd3, 5'd5, 5'd8, 6'h22));     expect1(pc, 1'b1, 5'd8, 32'h7FFF_FFFF);
    loadAndStart();
    for (int k = 0; k < expPc.size(); k++) begin
      checks++;
      if (pc_o !== expPc[k] || wb_en_o !== expEn[k] ||
          (expEn[k] && (wb_addr_o !== expAddr[k] || wb_data_o !== expData[k]))) begin
        errors++;
        $display("[TB] FAIL edge[%0d]: got pc=%h en=%b addr=%0d data=%h expected pc=%h en=%b addr=%0d data=%h",
                 k, pc_o, wb_en_o, wb_addr_o, wb_data_o, expPc[k], expEn[k], expAddr[k], expData[k]);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    clearQueues();
    prog.push_back(iType(6'h08, 5'd0, 5'd1, 16'd5));
    prog.push_back(iType(6'h08, 5'd1, 5'd2, 16'd1));
    prog.push_back(iType(6'h2B, 5'd0, 5'd2, 16'd4));
    loadAndStart();
    tick(); tick(); tick();
    checks++;
    if (pc_o !== 32'h0C) begin
      errors++;
      $display("[TB] FAIL midreset_pre_pc: got %h expected %h", pc_o, 32'h0C);
    end
    #2;
    initiate = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'd0 || wb_en_o !== 1'b1 || wb_data_o !== 32'd5) begin
      errors++;
      $display("[TB] FAIL midreset_async: got pc=%h en=%b data=%h expected pc=0 en=1 data=5",
               pc_o, wb_en_o, wb_data_o);
    end
    checks++;
    if (dut.regs_q[1] !== 32'd0 || dut.regs_q[2] !== 32'd0 || dut.dmem_q[1] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got r1=%h r2=%h m1=%h expected all 0",
               dut.regs_q[1], dut.regs_q[2], dut.dmem_q[1]);
    end
    @(negedge clk);
    initiate = 1'b1;
    #1;
    tick();
    checks++;
    if (pc_o !== 32'h04 || wb_data_o !== 32'd6) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got pc=%h data=%h expected pc=4 data=6", pc_o, wb_data_o);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    initiate = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_memory();
    test_branch();
    test_edge();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
